// File: rtl/bootrom_arbiter_pkg.sv
// Shared types and constants for the boot ROM arbiter and its ROM integration.
// The owner field is wide enough for up to 16 requesters.
package bootrom_arbiter_pkg;

   localparam int BROM_ADDR_WIDTH  = 24;
   localparam int BROM_DATA_WIDTH  = 128;
   localparam int BROM_OWNER_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } brom_arb_state_t;

   typedef struct packed {
      logic [BROM_ADDR_WIDTH-1:0]  addr;
      logic [BROM_OWNER_WIDTH-1:0] owner;
   } brom_req_t;

   // Round-robin successor of the owner that was just served
   function automatic logic [BROM_OWNER_WIDTH-1:0] rr_advance(
      input logic [BROM_OWNER_WIDTH-1:0] owner,
      input int unsigned                 num_req
   );
      return ((32'(owner) + 32'd1) >= num_req) ? '0
                                                : owner + {{(BROM_OWNER_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/bootrom_arbiter_if.sv
// Requester-side and boot-ROM-side bus of the arbiter.
// 'slave' is the arbiter's view, 'master' is the surrounding tile and ROM.
interface bootrom_arbiter_if
   import bootrom_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = BROM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BROM_DATA_WIDTH
);

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            resp_valid_o;
   logic [DATA_WIDTH-1:0]         resp_data_o;
   logic                          resp_error_o;
   logic [ADDR_WIDTH-1:0]         brom_req_address_o;
   logic                          brom_req_valid_o;
   logic                          brom_ready_i;
   logic [DATA_WIDTH-1:0]         brom_resp_data_i;
   logic                          brom_resp_valid_i;
   logic                          busy_o;

   modport slave (
      input  req_valid_i, req_addr_i, brom_ready_i, brom_resp_data_i, brom_resp_valid_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
             brom_req_address_o, brom_req_valid_o, busy_o
   );

   modport master (
      output req_valid_i, req_addr_i, brom_ready_i, brom_resp_data_i, brom_resp_valid_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
             brom_req_address_o, brom_req_valid_o, busy_o
   );

endinterface

// File: rtl/bootrom_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import bootrom_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [IDX_W-1:0] cand_s;

   // Scan from the pointer and stop at the first active request
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand_s    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = IDX_W'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
         if (!grant_any && req[cand_s]) begin
            grant[cand_s] = 1'b1;
            grant_idx     = cand_s;
            grant_any     = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

endmodule

// File: rtl/bootrom_arbiter.sv
// Shares one boot ROM read port among NUM_REQ requesters, one transaction at a time,
// with round-robin fairness and a watchdog that turns a silent ROM into an error response.
module bootrom_arbiter
   import bootrom_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = BROM_ADDR_WIDTH,
   parameter int DATA_WIDTH     = BROM_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic               clk,
   input logic               rst,
   bootrom_arbiter_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   brom_arb_state_t       state_r;
   logic [IDX_W-1:0]      rr_ptr_r;
   logic [WD_W-1:0]       wdog_r;
   brom_req_t             pend_r;
   logic [NUM_REQ-1:0]    resp_valid_r;
   logic                  resp_error_r;
   logic [DATA_WIDTH-1:0] resp_data_r;
   logic                  brom_req_valid_r;
   logic                  busy_r;

   logic [NUM_REQ-1:0]    grant_s;
   logic [IDX_W-1:0]      grant_idx_s;
   logic                  grant_any_s;
   logic [ADDR_WIDTH-1:0] req_addr_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (bus.req_valid_i),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   // Address of the currently granted requester
   always_comb begin
      req_addr_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_addr_s = req_addr_s |
                      ({ADDR_WIDTH{grant_s[k]}} & bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
      end
   end

   // Transaction FSM, watchdog, pending request and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         rr_ptr_r         <= '0;
         wdog_r           <= '0;
         pend_r           <= '0;
         resp_valid_r     <= '0;
         resp_error_r     <= 1'b0;
         resp_data_r      <= '0;
         brom_req_valid_r <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         resp_valid_r     <= '0;
         brom_req_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_any_s) begin
                  pend_r.addr  <= BROM_ADDR_WIDTH'(req_addr_s);
                  pend_r.owner <= BROM_OWNER_WIDTH'(grant_idx_s);
                  state_r      <= ST_ISSUE;
                  busy_r       <= 1'b1;
               end
            end
            ST_ISSUE: begin
               wdog_r <= '0;
               if (bus.brom_ready_i) begin
                  brom_req_valid_r <= 1'b1;
                  state_r          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               wdog_r <= wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
               // A response in the terminal-count cycle still wins over the timeout
               if (bus.brom_resp_valid_i || (wdog_r == WD_W'(TIMEOUT_CYCLES - 1))) begin
                  resp_valid_r <= NUM_REQ'(1'b1) << pend_r.owner;
                  resp_error_r <= !bus.brom_resp_valid_i;
                  resp_data_r  <= bus.brom_resp_valid_i ? bus.brom_resp_data_i : '0;
                  rr_ptr_r     <= IDX_W'(rr_advance(pend_r.owner, NUM_REQ));
                  state_r      <= ST_IDLE;
                  busy_r       <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready_o        = (state_r == ST_IDLE) ? grant_s : '0;
   assign bus.resp_valid_o       = resp_valid_r;
   assign bus.resp_data_o        = resp_data_r;
   assign bus.resp_error_o       = resp_error_r;
   assign bus.brom_req_address_o = ADDR_WIDTH'(pend_r.addr);
   assign bus.brom_req_valid_o   = brom_req_valid_r;
   assign bus.busy_o             = busy_r;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Scoreboard bench for bootrom_arbiter: directed latency/contention/timeout/reset cases,
// then randomized traffic, all checked against a rule-level arbitration and ROM model.
module tb_bootrom_arbiter;

   localparam int N  = 2;
   localparam int AW = 24;
   localparam int DW = 128;
   localparam int TC = 16;

   typedef struct {
      int           owner;
      logic [DW-1:0] data;
      logic         err;
      int           lat;
      int           cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  drv_valid = '0;
   logic [AW-1:0] drv_addr [N];
   logic          rom_ready = 1'b1;
   logic          rom_resp_valid = 1'b0;
   logic [DW-1:0] rom_resp_data = '0;
   logic [AW-1:0] rom_addr = '0;
   logic [AW-1:0] rom_seen_addr = '0;
   logic [N-1:0]  acc_mask = '0;
   bit            rom_mute = 1'b0;
   bit            inject_late = 1'b0;
   bit            m_busy = 1'b0;
   int            m_ptr = 0;
   int            cyc = 0, total = 0, bad = 0, resp_count = 0, exp_lat = 0;
   int            rom_cnt = 0, rom_pulses = 0, rom_last_pulse_cyc = 0;
   int            acc_log[$];
   int            acc_cyc_log[$];
   exp_t          exp_q[$];

   bootrom_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bootrom_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.req_valid_i       = drv_valid;
   assign bus.brom_ready_i      = rom_ready;
   assign bus.brom_resp_valid_i = rom_resp_valid;
   assign bus.brom_resp_data_i  = rom_resp_data;
   for (genvar g = 0; g < N; g++) begin : g_addr
      assign bus.req_addr_i[g*AW +: AW] = drv_addr[g];
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rom_line(input logic [AW-1:0] a);
      logic [31:0] h;
      h = {12'h000, a[23:4]} * 32'h9E37_79B9 + 32'h1234_5678;
      return {h, ~h, h ^ 32'hDEAD_BEEF, {8'h00, a}};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural ROM: answers 4 cycles after a request pulse unless muted
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rom_resp_valid = 1'b0;
         if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin
               rom_resp_valid = 1'b1;
               rom_resp_data  = rom_line(rom_addr);
            end
         end
         if (inject_late) begin
            rom_resp_valid = 1'b1;
            rom_resp_data  = '1;
            inject_late    = 1'b0;
         end
         if (bus.brom_req_valid_o) begin
            rom_pulses++;
            rom_last_pulse_cyc = cyc;
            rom_seen_addr      = bus.brom_req_address_o;
            if (!rom_mute) begin
               rom_cnt  = 4;
               rom_addr = bus.brom_req_address_o;
            end
         end
      end
   end

   // Monitor: scoreboard pop on responses, arbitration rule check, push on accepts
   initial begin
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_onehot;
      exp_t         e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            m_busy   = 1'b0;
            m_ptr    = 0;
            acc_mask = '0;
         end else begin
            if (bus.resp_valid_o != '0) begin
               resp_count++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", bus.resp_valid_o, '0);
               end else begin
                  e = exp_q.pop_front();
                  exp_onehot = '0;
                  exp_onehot[e.owner] = 1'b1;
                  chk("resp_owner", bus.resp_valid_o, exp_onehot);
                  chk("resp_data", bus.resp_data_o, e.data);
                  chk("resp_error", bus.resp_error_o, e.err);
                  if (e.lat != 0) chk("resp_latency", cyc - e.cyc, e.lat);
                  m_ptr  = (e.owner + 1) % N;
                  m_busy = 1'b0;
               end
            end
            exp_ready = '0;
            if (!m_busy) begin
               for (int k = 0; k < N; k++) begin
                  if (exp_ready == '0 && drv_valid[(m_ptr + k) % N]) exp_ready[(m_ptr + k) % N] = 1'b1;
               end
            end
            chk("req_ready", bus.req_ready_o, exp_ready);
            acc_mask = drv_valid & bus.req_ready_o;
            for (int k = 0; k < N; k++) begin
               if (acc_mask[k]) begin
                  e.owner = k;
                  e.data  = rom_mute ? '0 : rom_line(drv_addr[k]);
                  e.err   = rom_mute;
                  e.lat   = exp_lat;
                  e.cyc   = cyc;
                  exp_q.push_back(e);
                  acc_log.push_back(k);
                  acc_cyc_log.push_back(cyc);
                  m_busy = 1'b1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   task automatic wait_acc(input int i, input bit keep);
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         if (acc_mask[i]) begin
            if (!keep) drv_valid[i] = 1'b0;
            return;
         end
      end
      total++; bad++;
      $display("FAIL wait_acc: requester %0d not accepted within 400 cycles", i);
   endtask

   task automatic wait_quiet();
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         if (!m_busy && exp_q.size() == 0) return;
      end
      total++; bad++;
      $display("FAIL wait_quiet: %0d responses still outstanding after 400 cycles", exp_q.size());
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int b, p0, r0;
      for (int k = 0; k < N; k++) drv_addr[k] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", bus.resp_valid_o, '0);
      chk("rst_resp_error", bus.resp_error_o, 1'b0);
      chk("rst_resp_data", bus.resp_data_o, '0);
      chk("rst_brom_valid", bus.brom_req_valid_o, 1'b0);
      chk("rst_brom_addr", bus.brom_req_address_o, '0);
      chk("rst_busy", bus.busy_o, 1'b0);

      // single request
      @(posedge clk); #1;
      exp_lat = 7;
      p0 = rom_pulses;
      drv_valid[0] = 1'b1; drv_addr[0] = 24'h000010;
      @(negedge clk);
      chk("t1_busy_before_accept", bus.busy_o, 1'b0);
      wait_acc(0, 1'b0);
      @(negedge clk);
      chk("t1_busy_after_accept", bus.busy_o, 1'b1);
      wait_quiet();
      chk("t1_rom_addr", rom_seen_addr, 24'h000010);
      chk("t1_rom_pulses", rom_pulses - p0, 1);

      // contention from reset, back-to-back accepts
      do_reset();
      b = acc_log.size();
      drv_valid = '1; drv_addr[0] = 24'h000100; drv_addr[1] = 24'h000200;
      for (int n = 0; n < 200 && acc_log.size() < b + 4; n++) begin
         @(posedge clk); #1;
      end
      drv_valid = '0;
      wait_quiet();
      if (acc_log.size() >= b + 4) begin
         for (int k = 0; k < 4; k++) chk("t2_grant_order", acc_log[b + k], k % 2);
         for (int k = 0; k < 3; k++) chk("t2_b2b_gap", acc_cyc_log[b + k + 1] - acc_cyc_log[b + k], 7);
      end else begin
         chk("t2_grant_count", acc_log.size() - b, 4);
      end

      // ROM not ready for 5 cycles after accept
      @(posedge clk); #1;
      exp_lat = 12;
      p0 = rom_pulses;
      rom_ready = 1'b0;
      drv_valid[0] = 1'b1; drv_addr[0] = 24'h000040;
      wait_acc(0, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      rom_ready = 1'b1;
      wait_quiet();
      chk("t3_rom_pulses", rom_pulses - p0, 1);
      chk("t3_pulse_cycle", rom_last_pulse_cyc - acc_cyc_log[acc_log.size() - 1], 7);

      // watchdog timeout, then a late response that must be dropped
      exp_lat = TC + 2;
      rom_mute = 1'b1;
      drv_valid[0] = 1'b1; drv_addr[0] = 24'h000080;
      wait_acc(0, 1'b0);
      wait_quiet();
      rom_mute = 1'b0;
      r0 = resp_count;
      inject_late = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      chk("t4_late_dropped", resp_count - r0, 0);

      // reset three cycles after issue aborts the transaction
      exp_lat = 7;
      r0 = resp_count;
      drv_valid[1] = 1'b1; drv_addr[1] = 24'h000030;
      wait_acc(1, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_busy_after_rst", bus.busy_o, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      chk("t5_no_resp", resp_count - r0, 0);
      b = acc_log.size();
      drv_valid = '1; drv_addr[0] = 24'h000050; drv_addr[1] = 24'h000030;
      wait_acc(0, 1'b0);
      wait_acc(1, 1'b0);
      wait_quiet();
      chk("t5_first_grant_after_rst", acc_log[b], 0);

      // randomized traffic with a randomly stalling ROM
      exp_lat = 0;
      for (int n = 0; n < 2500; n++) begin
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            if (acc_mask[k] || !drv_valid[k]) begin
               drv_valid[k] = ($urandom_range(0, 2) == 0);
               drv_addr[k]  = AW'($urandom);
            end
         end
         rom_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      drv_valid = '0;
      rom_ready = 1'b1;
      wait_quiet();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
